// File: rtl/ysyx_2022040010_div_pkg.sv
// Shared types and constants for the RV64M divide unit.
package ysyx_2022040010_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam int unsigned DIV_ITER_64 = 64;
    localparam int unsigned DIV_ITER_32 = 32;

    localparam logic [63:0] MIN_NEG_64      = 64'h8000_0000_0000_0000;
    // Most negative 32-bit value as it appears after sign extension.
    localparam logic [63:0] MIN_NEG_32_SEXT = 64'hFFFF_FFFF_8000_0000;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/ysyx_2022040010_add.sv
// 64-bit adder with carry in/out; alu_32 selects a 32-bit add with sign-extended sum.
module ysyx_2022040010_add (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        in_c,
    input  logic        alu_32,
    output logic [63:0] sum,
    output logic        out_c
);

    logic [64:0] s64;
    logic [32:0] s32;

    always_comb begin
        s64 = {1'b0, a} + {1'b0, b} + {64'd0, in_c};
        s32 = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, in_c};
        if (alu_32) begin
            sum   = {{32{s32[31]}}, s32[31:0]};
            out_c = s32[32];
        end else begin
            sum   = s64[63:0];
            out_c = s64[64];
        end
    end

endmodule

// File: rtl/ysyx_2022040010_div.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per CALC cycle; sign correction happens in a single FIX cycle.
module ysyx_2022040010_div
    import ysyx_2022040010_div_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic            div_signed,
    input  logic            div_rem,
    input  logic            div_32,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    div_state_e      state;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [6:0]      cnt;
    logic            q_neg;
    logic            r_neg;
    logic            is_32;
    logic            is_rem;

    logic            accept;
    logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b;
    logic            a_neg, b_neg;
    logic            is_zero, is_ovf;
    logic [XLEN-1:0] spec_res;

    assign accept = div_valid && div_ready && !flush;

    // Operand preparation and special-case detection, evaluated on the accept cycle.
    always_comb begin
        if (div_32) begin
            a_ext = div_signed ? sext32(dividend[31:0]) : {32'd0, dividend[31:0]};
            b_ext = div_signed ? sext32(divisor[31:0])  : {32'd0, divisor[31:0]};
        end else begin
            a_ext = dividend;
            b_ext = divisor;
        end
        a_neg   = div_signed & a_ext[XLEN-1];
        b_neg   = div_signed & b_ext[XLEN-1];
        abs_a   = a_neg ? (~a_ext + 64'd1) : a_ext;
        abs_b   = b_neg ? (~b_ext + 64'd1) : b_ext;
        is_zero = (b_ext == '0);
        is_ovf  = div_signed && (b_ext == '1) &&
                  (a_ext == (div_32 ? MIN_NEG_32_SEXT : MIN_NEG_64));
        if (is_zero) begin
            if (div_rem) spec_res = div_32 ? sext32(dividend[31:0]) : dividend;
            else         spec_res = '1;
        end else begin
            spec_res = div_rem ? '0 : a_ext;
        end
    end

    // Trial subtract: partial - divisor via partial + ~divisor + 1.
    logic [XLEN:0]   partial;
    logic [XLEN-1:0] diff;
    logic            carry;
    logic            ge;

    assign partial = {rem_q, quo_q[XLEN-1]};

    ysyx_2022040010_add u_add (
        .a      (partial[XLEN-1:0]),
        .b      (~dvs_q),
        .in_c   (1'b1),
        .alu_32 (1'b0),
        .sum    (diff),
        .out_c  (carry)
    );

    assign ge = partial[XLEN] | carry;

    logic [XLEN-1:0] q_fix, r_fix, sel, fix_res;

    always_comb begin
        q_fix   = q_neg ? (~quo_q + 64'd1) : quo_q;
        r_fix   = r_neg ? (~rem_q + 64'd1) : rem_q;
        sel     = is_rem ? r_fix : q_fix;
        fix_res = is_32 ? sext32(sel[31:0]) : sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_ready <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            is_32     <= 1'b0;
            is_rem    <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            div_ready <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        div_ready <= 1'b0;
                        is_32     <= div_32;
                        is_rem    <= div_rem;
                        q_neg     <= a_neg ^ b_neg;
                        r_neg     <= a_neg;
                        if (is_zero || is_ovf) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= spec_res;
                        end else begin
                            state <= ST_CALC;
                            rem_q <= '0;
                            // W forms are left-justified so the same 64-step shifter serves both widths.
                            quo_q <= div_32 ? {abs_a[31:0], 32'd0} : abs_a;
                            dvs_q <= abs_b;
                            cnt   <= div_32 ? 7'(DIV_ITER_32) : 7'(DIV_ITER_64);
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= ge ? diff : partial[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], ge};
                    cnt   <= cnt - 7'd1;
                    if (cnt == 7'd1) state <= ST_FIX;
                end
                ST_FIX: begin
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                    result    <= fix_res;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        div_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
